seg7_scan_driver: RTL



---
 rtl/seg7_pkg.sv | 41 ++++
 rtl/seg7_scan_driver_bcd_to_seg7.sv | 37 +++
 rtl/seg7_scan_driver.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared definitions for the eight-digit seven-segment scan
//                driver: active-low segment patterns {g,f,e,d,c,b,a}, digit
//                count, scan FSM state encoding and an anode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int c_NUM_DIGITS = 8;
    localparam int c_DIGIT_W    = 3;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_SEG_0     = 7'h40;
    localparam logic [6:0] c_SEG_1     = 7'h79;
    localparam logic [6:0] c_SEG_2     = 7'h24;
    localparam logic [6:0] c_SEG_3     = 7'h30;
    localparam logic [6:0] c_SEG_4     = 7'h19;
    localparam logic [6:0] c_SEG_5     = 7'h12;
    localparam logic [6:0] c_SEG_6     = 7'h02;
    localparam logic [6:0] c_SEG_7     = 7'h78;
    localparam logic [6:0] c_SEG_8     = 7'h00;
    localparam logic [6:0] c_SEG_9     = 7'h10;
    localparam logic [6:0] c_SEG_DASH  = 7'h3F;
    localparam logic [6:0] c_SEG_BLANK = 7'h7F;

    // Scan FSM: ON drives one anode, GUARD turns every anode off so the
    // segment lines can settle before the next digit is selected.
    typedef enum logic [0:0] {
        ST_ON    = 1'b0,
        ST_GUARD = 1'b1
    } scan_state_t;

    // Active-low one-cold anode vector selecting digit idx
    function automatic logic [7:0] anode_for(input logic [c_DIGIT_W-1:0] idx);
        return ~(8'(8'h01 << idx));
    endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_seg7
//  Description : Combinational 4-bit code to active-low seven-segment
//                pattern {g,f,e,d,c,b,a}. Codes 0..9 give the decimal
//                glyphs; 10..15 give a dash so a bad converter result is
//                visible rather than silently wrong.
//  Ports       : i_code [3:0] - digit code
//                o_seg  [6:0] - active-low segment pattern
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_SEG_DASH;
        case (i_code)
            4'd0:    o_seg = c_SEG_0;
            4'd1:    o_seg = c_SEG_1;
            4'd2:    o_seg = c_SEG_2;
            4'd3:    o_seg = c_SEG_3;
            4'd4:    o_seg = c_SEG_4;
            4'd5:    o_seg = c_SEG_5;
            4'd6:    o_seg = c_SEG_6;
            4'd7:    o_seg = c_SEG_7;
            4'd8:    o_seg = c_SEG_8;
            4'd9:    o_seg = c_SEG_9;
            default: o_seg = c_SEG_DASH;
        endcase
    end

endmodule : bcd_to_seg7
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed driver for an eight-digit common-anode
//                seven-segment display. Each digit is lit for ON_CYC cycles
//                followed by GUARD_CYC cycles with all anodes off. New data
//                is captured into a shadow register on load and transferred
//                to the display register only at a frame boundary, so a frame
//                never shows a mix of old and new digits.
//  Config      : SEG7_LZB_EN - when defined, leading zeros above both the
//                highest non-zero digit and the lit decimal point are blanked
//                (digit 0 is always shown).
//  Ports       : clk        - system clock
//                reset      - synchronous active-high reset
//                bcd_in     - eight BCD digits, [3:0] = digit 0
//                dp_en      - decimal point enable
//                dp_pos     - digit index carrying the decimal point
//                load       - one-cycle capture strobe
//                an         - anode enables, active-low, an[i] = digit i
//                seg        - segments {g,f,e,d,c,b,a}, active-low
//                dp         - decimal point segment, active-low
//                frame_tick - one-cycle pulse on the first cycle of digit 0
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned ON_CYC    = 100000,
    parameter int unsigned GUARD_CYC = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bcd_in,
    input  logic        dp_en,
    input  logic [2:0]  dp_pos,
    input  logic        load,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    // One counter is shared by both phases, so it is sized for the longer one
    localparam int unsigned c_CNT_MAX = (ON_CYC > GUARD_CYC) ? ON_CYC : GUARD_CYC;
    localparam int          c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_ON_LAST    = c_CNT_W'(ON_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_GUARD_LAST = c_CNT_W'(GUARD_CYC - 1);
    localparam logic [c_DIGIT_W-1:0] c_LAST_DIGIT = c_DIGIT_W'(c_NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // Scan FSM state
    // ------------------------------------------------------------------
    scan_state_t          r_state;
    scan_state_t          w_state_nxt;
    logic [c_DIGIT_W-1:0] r_digit;
    logic [c_DIGIT_W-1:0] w_digit_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 w_frame_end;

    // ------------------------------------------------------------------
    // Shadow and display registers
    // ------------------------------------------------------------------
    logic [31:0]          r_shadow_bcd;
    logic                 r_shadow_dp_en;
    logic [c_DIGIT_W-1:0] r_shadow_dp_pos;
    logic [31:0]          r_disp_bcd;
    logic                 r_disp_dp_en;
    logic [c_DIGIT_W-1:0] r_disp_dp_pos;

    logic [3:0]           w_code;
    logic [6:0]           w_seg_dec;
    logic                 w_blank;
    logic                 w_dp_lit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ON;
            r_digit <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_digit <= w_digit_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_frame_end = 1'b0;
        case (r_state)
            ST_ON: begin
                if (r_cnt == c_ON_LAST) begin
                    w_state_nxt = ST_GUARD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GUARD: begin
                if (r_cnt == c_GUARD_LAST) begin
                    w_state_nxt = ST_ON;
                    w_cnt_nxt   = '0;
                    // 3-bit index wraps 7 -> 0 naturally
                    w_digit_nxt = r_digit + 1'b1;
                    w_frame_end = (r_digit == c_LAST_DIGIT);
                end
            end
            default: begin
                w_state_nxt = ST_ON;
                w_digit_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A load coinciding with the frame boundary lands in the shadow only;
    // the display register picks up the shadow contents from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow_bcd    <= '0;
            r_shadow_dp_en  <= 1'b0;
            r_shadow_dp_pos <= '0;
            r_disp_bcd      <= '0;
            r_disp_dp_en    <= 1'b0;
            r_disp_dp_pos   <= '0;
        end else begin
            if (load) begin
                r_shadow_bcd    <= bcd_in;
                r_shadow_dp_en  <= dp_en;
                r_shadow_dp_pos <= dp_pos;
            end
            if (w_frame_end) begin
                r_disp_bcd      <= r_shadow_bcd;
                r_disp_dp_en    <= r_shadow_dp_en;
                r_disp_dp_pos   <= r_shadow_dp_pos;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit decode
    // ------------------------------------------------------------------
    assign w_code   = r_disp_bcd[{r_digit, 2'b00} +: 4];
    assign w_dp_lit = r_disp_dp_en && (r_digit == r_disp_dp_pos);

    bcd_to_seg7 u_bcd_to_seg7 (
        .i_code (w_code),
        .o_seg  (w_seg_dec)
    );

`ifdef SEG7_LZB_EN
    // Highest digit index holding a non-zero code; dash codes count as
    // non-zero so an invalid result is never hidden.
    logic [c_DIGIT_W-1:0] w_hi_nz;

    always_comb begin
        w_hi_nz = '0;
        for (int i = 1; i < c_NUM_DIGITS; i++) begin
            if (r_disp_bcd[i*4 +: 4] != 4'd0) begin
                w_hi_nz = c_DIGIT_W'(i);
            end
        end
    end

    // Keep every digit up to the decimal point so "0.05" style values
    // still show their leading zero before the point.
    assign w_blank = (r_digit != '0) &&
                     (r_digit > w_hi_nz) &&
                     (!r_disp_dp_en || (r_digit > r_disp_dp_pos));
`else
    assign w_blank = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registered outputs: reflect the state held during the previous cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            an         <= 8'hFF;
            seg        <= c_SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (r_state == ST_ON) && (r_digit == '0) && (r_cnt == '0);
            if (r_state == ST_ON) begin
                an  <= anode_for(r_digit);
                seg <= w_blank ? c_SEG_BLANK : w_seg_dec;
                dp  <= ~w_dp_lit;
            end else begin
                an  <= 8'hFF;
                seg <= c_SEG_BLANK;
                dp  <= 1'b1;
            end
        end
    end

endmodule : seg7_scan_driver
`default_nettype wire
